err_monitor: RTL and testbench
==============================

Name: err_monitor

Overview:
- Parametrised successor to the board-level error/status indicator.
- Monitors NUM_ERR error lines, each with a configurable priority (high or low), and debounces every line.
- Latches a fault until the operator acknowledges it.
- Records which channel faulted first and counts fault events.
- Drives the RGB LED and the five leftmost seven-segment digits with "Err<ch>" or "run".

Parameters:
- NUM_ERR, 4: number of error input channels, 1..16.
- HIGH_MASK, 4'b1000 (NUM_ERR bits): bit i = 1 makes channel i high priority; 0 makes it low priority.
- LOW_THRESH, 2: number of simultaneously active low-priority channels that constitutes a fault, 1..NUM_ERR.
- DEBOUNCE, 3: cycles a raw input must differ from its filtered value before the filtered value updates, >= 1.

Ports:
- hz100  input  1  system clock
- reset  input  1  synchronous, active-high reset
- err_in  input  NUM_ERR  raw error lines, asynchronous to hz100 (pushbuttons)
- ack  input  1  operator acknowledge, level-sampled; one cycle high is sufficient
- status  output  1  1 = latched fault present
- red  output  1  equals status
- green  output  1  equals ~status
- first_ch  output  4  index of the channel that caused the latched fault
- fault_count  output  8  saturating count of RUN->FAULT transitions
- ss7, ss6, ss5, ss4, ss3  output  8 each  segment patterns; bit7 = dp (always 0); bits 6:0 = g..a

Behaviour:
- Reset (synchronous, on a hz100 edge with reset = 1):
  - state = RUN, all filtered lines = 0, all debounce counters = 0.
  - first_ch = 0, fault_count = 0.
  - status = 0, red = 0, green = 1, display shows "run".
- Debounce, per channel:
  - If raw == filtered, the counter clears.
  - Otherwise the counter increments.
  - When the counter == DEBOUNCE-1 and raw still differs, filtered <= raw and the counter clears.
  - A held step therefore reaches filtered DEBOUNCE cycles after it is first sampled. Any glitch shorter than DEBOUNCE cycles is ignored.
- Fault condition (combinational on the filtered lines):
  - fault_now = |(filt & HIGH_MASK) | (popcount(filt & ~HIGH_MASK) >= LOW_THRESH).
- Culprit (combinational):
  - The lowest-index active high-priority channel if one exists.
  - Otherwise the lowest-index active low-priority channel.
- FSM, states RUN, FAULT, ACKED:
  - RUN -> FAULT when fault_now. On the same edge first_ch <= culprit and fault_count <= fault_count+1, saturating at 255.
  - FAULT -> ACKED on ack. In FAULT, first_ch is frozen; later channels never overwrite it.
  - ACKED -> RUN when !fault_now.
  - ACKED -> FAULT when a new channel becomes active that was not active at ack time. The filtered snapshot is taken on the ack edge. This transition updates first_ch to that new channel's culprit and increments fault_count.
  - ack in RUN or ACKED is ignored.
  - ack in FAULT with fault_now = 0 still goes to ACKED, then to RUN on the next edge.
  - ack and a new fault on the same edge in FAULT: ack wins; the new channel is already in the snapshot.
- Outputs:
  - status = (state != RUN). It is registered state, so status rises one cycle after filtered fault_now.
  - Total latency from a held raw input to status = DEBOUNCE+1 cycles.
- Display:
  - In FAULT or ACKED, ss7..ss3 show "E", "r", "r", blank, hex(first_ch).
  - In RUN, they show "r", "u", "n", blank, blank.
- Reset mid-operation has priority over all other inputs; any pending debounce or fault state is discarded.

Decomposition:
- Shared package err_pkg:
  - typedef enum logic [1:0] {RUN, FAULT, ACKED} err_state_t
  - seven-segment constants SEG_E, SEG_R, SEG_U, SEG_N, SEG_BLANK
  - hex digit table SEG_HEX[16]
- One sub-module, err_debounce: a single-channel filter parametrised by DEBOUNCE, instantiated NUM_ERR times in a generate loop.
- Top-level err_monitor holds the priority encoder, popcount, FSM, counter and display mux.

Test Plan (NUM_ERR = 4, HIGH_MASK = 4'b1000, LOW_THRESH = 2, DEBOUNCE = 3):
1. Reset high 2 cycles, then low with err_in = 0 -> status = 0, green = 1, ss7..ss3 = "run", fault_count = 0.
2. err_in = 4'b1000 held -> status = 1 exactly 4 cycles after the first sample; first_ch = 3; ss3 = hex 3; fault_count = 1.
3. err_in = 4'b0001 for 2 cycles, then 0 -> status stays 0. Then err_in = 4'b0011 held -> status = 1, first_ch = 0.
4. From test 3's fault, pulse ack one cycle, then drop err_in to 0 -> status stays 1 until filtered clears, then status = 0 within DEBOUNCE+1 cycles; display "run".
5. In ACKED with err_in = 4'b0011, raise bit 3 -> FAULT re-entered, first_ch = 3, fault_count increments by 1.
6. Produce 256 fault/ack/clear cycles -> fault_count saturates at 255. Assert reset mid-fault -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/err_pkg.sv
// Shared types, seven-segment glyphs and small bit-vector helpers for the error monitor.
package err_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FAULT = 2'd1,
    ACKED = 2'd2
  } err_state_t;

  // Segment bit order: bit7 = dp, bits 6:0 = g..a
  localparam logic [7:0] SEG_E     = 8'h79;
  localparam logic [7:0] SEG_R     = 8'h50;
  localparam logic [7:0] SEG_U     = 8'h1C;
  localparam logic [7:0] SEG_N     = 8'h54;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [7:0] SEG_HEX [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  function automatic logic [3:0] lowest_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  // High-priority channels win; otherwise the lowest active low-priority one.
  function automatic logic [3:0] culprit(input logic [15:0] v, input logic [15:0] mask);
    if (|(v & mask)) return lowest_index(v & mask);
    return lowest_index(v & ~mask);
  endfunction

  // ss7..ss3 packed MSB first.
  function automatic logic [39:0] seg_row(input err_state_t s, input logic [3:0] ch);
    if (s == RUN) return {SEG_R, SEG_U, SEG_N, SEG_BLANK, SEG_BLANK};
    return {SEG_E, SEG_R, SEG_R, SEG_BLANK, SEG_HEX[ch]};
  endfunction

endpackage

// File: rtl/err_monitor_debounce.sv
// Single-channel debounce filter: the filtered value follows raw only after
// raw has differed from it for DEBOUNCE consecutive samples.
module err_debounce #(
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic hz100,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge hz100) begin
    if (reset) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (raw == filt) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE - 1)) begin
      filt <= raw;
      cnt  <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/err_monitor.sv
// Error monitor top: debounced inputs, priority fault detection, latched
// fault FSM with acknowledge, first-culprit capture, event counter and display.
module err_monitor
  import err_pkg::*;
#(
  parameter int unsigned          NUM_ERR    = 4,
  parameter logic [NUM_ERR-1:0]   HIGH_MASK  = NUM_ERR'(4'b1000),
  parameter int unsigned          LOW_THRESH = 2,
  parameter int unsigned          DEBOUNCE   = 3
) (
  input  logic               hz100,
  input  logic               reset,
  input  logic [NUM_ERR-1:0] err_in,
  input  logic               ack,
  output logic               status,
  output logic               red,
  output logic               green,
  output logic [3:0]         first_ch,
  output logic [7:0]         fault_count,
  output logic [7:0]         ss7,
  output logic [7:0]         ss6,
  output logic [7:0]         ss5,
  output logic [7:0]         ss4,
  output logic [7:0]         ss3
);

  logic [NUM_ERR-1:0] filt;
  logic [NUM_ERR-1:0] snap;
  logic [NUM_ERR-1:0] snap_nxt;
  logic [NUM_ERR-1:0] fresh_c;
  logic               fault_now_c;
  err_state_t         state;
  err_state_t         state_nxt;
  logic [3:0]         first_nxt;
  logic [7:0]         count_nxt;

  for (genvar i = 0; i < NUM_ERR; i++) begin : g_deb
    err_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .hz100 (hz100),
      .reset (reset),
      .raw   (err_in[i]),
      .filt  (filt[i])
    );
  end

  assign fault_now_c = (|(filt & HIGH_MASK)) ||
                       (popcount(16'(filt & ~HIGH_MASK)) >= 5'(LOW_THRESH));
  // Channels active now that were not active when the fault was acknowledged.
  assign fresh_c = filt & ~snap;

  always_comb begin
    state_nxt = state;
    first_nxt = first_ch;
    count_nxt = fault_count;
    snap_nxt  = snap;
    case (state)
      RUN: begin
        if (fault_now_c) begin
          state_nxt = FAULT;
          first_nxt = culprit(16'(filt), 16'(HIGH_MASK));
          if (fault_count != 8'hFF) count_nxt = fault_count + 8'd1;
        end
      end
      FAULT: begin
        if (ack) begin
          state_nxt = ACKED;
          snap_nxt  = filt;
        end
      end
      ACKED: begin
        if (!fault_now_c) begin
          state_nxt = RUN;
        end else if (|fresh_c) begin
          state_nxt = FAULT;
          first_nxt = culprit(16'(fresh_c), 16'(HIGH_MASK));
          if (fault_count != 8'hFF) count_nxt = fault_count + 8'd1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // All state and outputs registered together so the display tracks status exactly.
  always_ff @(posedge hz100) begin
    if (reset) begin
      state                   <= RUN;
      snap                    <= '0;
      first_ch                <= 4'd0;
      fault_count             <= 8'd0;
      status                  <= 1'b0;
      red                     <= 1'b0;
      green                   <= 1'b1;
      {ss7, ss6, ss5, ss4, ss3} <= {SEG_R, SEG_U, SEG_N, SEG_BLANK, SEG_BLANK};
    end else begin
      state                   <= state_nxt;
      snap                    <= snap_nxt;
      first_ch                <= first_nxt;
      fault_count             <= count_nxt;
      status                  <= (state_nxt != RUN);
      red                     <= (state_nxt != RUN);
      green                   <= (state_nxt == RUN);
      {ss7, ss6, ss5, ss4, ss3} <= seg_row(state_nxt, first_nxt);
    end
  end

endmodule

// File: tb/tb_err_monitor.sv
// Directed bench for err_monitor: expectations queued at stimulus time, popped and checked after the programmed latency.
module tb_err_monitor;

  logic       hz100 = 1'b0;
  logic       reset;
  logic       ack;
  logic [3:0] err_in;
  logic       status, red, green;
  logic [3:0] first_ch;
  logic [7:0] fault_count;
  logic [7:0] ss7, ss6, ss5, ss4, ss3;

  int unsigned tests = 0;
  int unsigned fails = 0;

  typedef struct {
    string       tag;
    logic [54:0] v;
  } exp_t;

  exp_t sb[$];

  err_monitor #(
    .NUM_ERR    (4),
    .HIGH_MASK  (4'b1000),
    .LOW_THRESH (2),
    .DEBOUNCE   (3)
  ) dut (
    .hz100       (hz100),
    .reset       (reset),
    .err_in      (err_in),
    .ack         (ack),
    .status      (status),
    .red         (red),
    .green       (green),
    .first_ch    (first_ch),
    .fault_count (fault_count),
    .ss7         (ss7),
    .ss6         (ss6),
    .ss5         (ss5),
    .ss4         (ss4),
    .ss3         (ss3)
  );

  always #5 hz100 = ~hz100;

  function automatic logic [7:0] digit(input logic [3:0] ch);
    case (ch)
      4'd0:    return 8'h3F;
      4'd3:    return 8'h4F;
      default: return 8'h00;
    endcase
  endfunction

  // {status, red, green, first_ch, fault_count, ss7, ss6, ss5, ss4, ss3}
  function automatic logic [54:0] mk(input bit st, input logic [3:0] ch, input logic [7:0] cnt);
    if (st) return {1'b1, 1'b1, 1'b0, ch, cnt, 8'h79, 8'h50, 8'h50, 8'h00, digit(ch)};
    return {1'b0, 1'b0, 1'b1, ch, cnt, 8'h50, 8'h1C, 8'h54, 8'h00, 8'h00};
  endfunction

  task automatic expect_out(input string tag, input bit st, input logic [3:0] ch, input logic [7:0] cnt);
    exp_t e;
    e.tag = tag;
    e.v   = mk(st, ch, cnt);
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [54:0] obs;
    obs = {status, red, green, first_ch, fault_count, ss7, ss6, ss5, ss4, ss3};
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: observed %h required a queued expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        fails++;
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge hz100);
    #1;
  endtask

  initial begin
    logic [7:0] n;
    reset  = 1'b1;
    ack    = 1'b0;
    err_in = 4'b0000;

    // 1: reset and idle
    expect_out("reset", 0, 4'd0, 8'd0);
    step(2); check();
    reset = 1'b0;
    expect_out("idle", 0, 4'd0, 8'd0);
    step(2); check();
    ack = 1'b1;
    expect_out("ack_in_run", 0, 4'd0, 8'd0);
    step(1); ack = 1'b0; check();

    // 2: high-priority channel, DEBOUNCE+1 latency
    err_in = 4'b1000;
    expect_out("hi_pre", 0, 4'd0, 8'd0);
    step(3); check();
    expect_out("hi_fault", 1, 4'd3, 8'd1);
    step(1); check();
    err_in = 4'b0000;
    expect_out("fault_held", 1, 4'd3, 8'd1);
    step(3); check();
    ack = 1'b1;
    expect_out("ack_no_fault", 1, 4'd3, 8'd1);
    step(1); ack = 1'b0; check();
    expect_out("back_to_run", 0, 4'd3, 8'd1);
    step(1); check();

    // 3: short glitch ignored, then two low-priority channels
    err_in = 4'b0001;
    step(2);
    err_in = 4'b0000;
    expect_out("glitch", 0, 4'd3, 8'd1);
    step(3); check();
    err_in = 4'b0011;
    expect_out("lo_pre", 0, 4'd3, 8'd1);
    step(3); check();
    expect_out("lo_fault", 1, 4'd0, 8'd2);
    step(1); check();

    // 4: ack then clear
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    err_in = 4'b0000;
    expect_out("acked_hold", 1, 4'd0, 8'd2);
    step(2); check();
    expect_out("acked_filt_clear", 1, 4'd0, 8'd2);
    step(1); check();
    expect_out("acked_to_run", 0, 4'd0, 8'd2);
    step(1); check();

    // 5: new channel while acknowledged re-enters FAULT
    err_in = 4'b0011;
    expect_out("lo_fault2", 1, 4'd0, 8'd3);
    step(4); check();
    ack = 1'b1;
    expect_out("acked2", 1, 4'd0, 8'd3);
    step(1); ack = 1'b0; check();
    err_in = 4'b1011;
    expect_out("new_pre", 1, 4'd0, 8'd3);
    step(3); check();
    expect_out("new_refault", 1, 4'd3, 8'd4);
    step(1); check();
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    err_in = 4'b0000;
    expect_out("clear5", 0, 4'd3, 8'd4);
    step(4); check();

    // 6: saturate the event counter
    for (int i = 0; i < 252; i++) begin
      n = (5 + i > 255) ? 8'd255 : 8'(5 + i);
      err_in = 4'b1000;
      expect_out("sat_fault", 1, 4'd3, n);
      step(4); check();
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      err_in = 4'b0000;
      step(4);
    end
    expect_out("sat_run", 0, 4'd3, 8'd255);
    step(1); check();
    err_in = 4'b1000;
    expect_out("sat_hold", 1, 4'd3, 8'd255);
    step(4); check();

    // Reset mid-fault
    reset = 1'b1;
    expect_out("mid_reset", 0, 4'd0, 8'd0);
    step(1); check();
    reset = 1'b0;
    err_in = 4'b0000;
    expect_out("post_reset", 0, 4'd0, 8'd0);
    step(5); check();

    if (sb.size() != 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
